// File: rtl/chrono_pkg.sv
// Shared types and elaboration-time helpers for the chrono alarm/chime sounder.
package chrono_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRing,
    StSnooze
  } chrono_state_e;

  typedef enum logic [1:0] {
    ToneSilent,
    ToneLow,
    ToneHigh
  } tone_sel_e;

  // Clock cycles per half tone period, minus one (terminal count of the divider).
  function automatic int unsigned half_period(int unsigned clk_hz, int unsigned tone_hz);
    return clk_hz / (2 * tone_hz) - 1;
  endfunction

  function automatic logic [7:0] to_bcd(int unsigned v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic bcd_lt(logic [7:0] a, logic [7:0] b);
    int unsigned av;
    int unsigned bv;
    av = 32'(a[7:4]) * 10 + 32'(a[3:0]);
    bv = 32'(b[7:4]) * 10 + 32'(b[3:0]);
    return av < bv;
  endfunction

endpackage

// File: rtl/chrono_tone_gen.sv
// Square-wave tone synthesiser: divides CP down to the low or high tone, silent otherwise.
module chrono_tone_gen
  import chrono_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 1_000_000,
  parameter int unsigned LOW_HZ  = 500,
  parameter int unsigned HIGH_HZ = 1000,
  parameter int unsigned DIV_W   = 16
) (
  input  logic      CP,
  input  logic      nCR,
  input  tone_sel_e tone_sel,
  output logic      AUDIO
);

  localparam logic [DIV_W-1:0] LOW_HALF  = DIV_W'(half_period(CLK_HZ, LOW_HZ));
  localparam logic [DIV_W-1:0] HIGH_HALF = DIV_W'(half_period(CLK_HZ, HIGH_HZ));

  tone_sel_e        sel_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] half;
  logic             phase_q;

  assign half = (tone_sel == ToneLow) ? LOW_HALF : HIGH_HALF;

  // On a select change the divider restarts at 1: the change cycle itself is the first count,
  // so the first rise lands exactly one half-period after the select register updated.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      sel_q   <= ToneSilent;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tone_sel != sel_q) begin
      sel_q   <= tone_sel;
      cnt_q   <= DIV_W'(1);
      phase_q <= 1'b0;
    end else if (tone_sel == ToneSilent) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q >= half) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
    end
  end

  // Mask the stale phase during the single cycle before a select change is absorbed.
  assign AUDIO = phase_q & (tone_sel == sel_q) & (tone_sel != ToneSilent);

endmodule

// File: rtl/chrono_alarm_chime.sv
// Hourly chime plus H:M alarm with stop/snooze, alarm taking priority over chime.
// Optional quiet-hours chime suppression is enabled by defining CHRONO_QUIET_HOURS_EN.
module chrono_alarm_chime
  import chrono_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1_000_000,
  parameter int unsigned LOW_HZ     = 500,
  parameter int unsigned HIGH_HZ    = 1000,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned N_LOW      = 4,
  parameter int unsigned ALARM_SEC  = 30,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
`ifdef CHRONO_QUIET_HOURS_EN
  ,
  parameter logic [7:0]  QUIET_START = 8'h22,
  parameter logic [7:0]  QUIET_END   = 8'h07
`endif
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       SEC_TICK,
  input  logic [7:0] TIME_H,
  input  logic [7:0] TIME_M,
  input  logic [7:0] TIME_S,
  input  logic [7:0] ALARM_H,
  input  logic [7:0] ALARM_M,
  input  logic       ALARM_EN,
  input  logic       CHIME_EN,
  input  logic       KEY_STOP,
  input  logic       KEY_SNOOZE,
  output logic       AUDIO,
  output logic       ALARM_ACTIVE,
  output logic       CHIME_ACTIVE
);

  localparam int unsigned RING_W = $clog2(ALARM_SEC + 1);
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_SEC + 1);
  localparam int unsigned NUM_W  = $clog2(MAX_SNOOZE + 1);

  chrono_state_e     state_q, state_d;
  tone_sel_e         sel_q, sel_d, chime_sel;
  logic [RING_W-1:0] ring_q, ring_d;
  logic [SNZ_W-1:0]  snz_q, snz_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic              chime_q, chime_d;
  logic              quiet;
  logic              alarm_match;

`ifdef CHRONO_QUIET_HOURS_EN
  always_comb begin
    if (bcd_lt(QUIET_START, QUIET_END)) begin
      quiet = !bcd_lt(TIME_H, QUIET_START) && bcd_lt(TIME_H, QUIET_END);
    end else if (bcd_lt(QUIET_END, QUIET_START)) begin
      quiet = !bcd_lt(TIME_H, QUIET_START) || bcd_lt(TIME_H, QUIET_END);
    end else begin
      quiet = 1'b0;
    end
  end
`else
  assign quiet = 1'b0;
`endif

  // Low beeps fall on the odd seconds 59-2k; the BCD patterns are elaboration constants.
  always_comb begin
    chime_sel = ToneSilent;
    if (CHIME_EN && !quiet && (TIME_M == 8'h59)) begin
      if (TIME_S == 8'h59) chime_sel = ToneHigh;
      for (int unsigned k = 1; k <= N_LOW; k++) begin
        if (TIME_S == to_bcd(59 - 2 * k)) chime_sel = ToneLow;
      end
    end
  end

  assign alarm_match = ALARM_EN && (TIME_H == ALARM_H) && (TIME_M == ALARM_M) &&
                       (TIME_S == 8'h00);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    num_d   = num_q;
    chime_d = chime_q;
    if (!ALARM_EN && (state_q != StIdle)) begin
      state_d = StIdle;
      sel_d   = ToneSilent;
    end else if (KEY_STOP && (state_q != StIdle)) begin
      state_d = StIdle;
      sel_d   = ToneSilent;
    end else if (KEY_SNOOZE && (state_q == StRing) && (num_q < NUM_W'(MAX_SNOOZE))) begin
      state_d = StSnooze;
      sel_d   = ToneSilent;
      snz_d   = '0;
      num_d   = num_q + NUM_W'(1);
    end else if (SEC_TICK) begin
      unique case (state_q)
        StIdle: begin
          if (alarm_match) begin
            // Entry tick is ring second 0, which sounds.
            state_d = StRing;
            sel_d   = ToneHigh;
            ring_d  = RING_W'(1);
            num_d   = '0;
            chime_d = 1'b0;
          end else begin
            sel_d   = chime_sel;
            chime_d = (chime_sel != ToneSilent);
          end
        end
        StRing: begin
          if (ring_q == RING_W'(ALARM_SEC)) begin
            state_d = StIdle;
            sel_d   = ToneSilent;
          end else begin
            sel_d  = ring_q[0] ? ToneSilent : ToneHigh;
            ring_d = ring_q + RING_W'(1);
          end
        end
        StSnooze: begin
          if (snz_q + SNZ_W'(1) == SNZ_W'(SNOOZE_SEC)) begin
            state_d = StRing;
            sel_d   = ToneHigh;
            ring_d  = RING_W'(1);
          end else begin
            snz_d = snz_q + SNZ_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          sel_d   = ToneSilent;
        end
      endcase
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q <= StIdle;
      sel_q   <= ToneSilent;
      ring_q  <= '0;
      snz_q   <= '0;
      num_q   <= '0;
      chime_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      num_q   <= num_d;
      chime_q <= chime_d;
    end
  end

  assign ALARM_ACTIVE = (state_q != StIdle);
  assign CHIME_ACTIVE = chime_q;

  chrono_tone_gen #(
    .CLK_HZ (CLK_HZ),
    .LOW_HZ (LOW_HZ),
    .HIGH_HZ(HIGH_HZ),
    .DIV_W  (DIV_W)
  ) u_tone_gen (
    .CP      (CP),
    .nCR     (nCR),
    .tone_sel(sel_q),
    .AUDIO   (AUDIO)
  );

endmodule

// File: tb/tb_chrono_alarm_chime.sv
// Bench for chrono_alarm_chime: chime vector table, random chime seconds against a
// second-level reference model, and hand-written alarm/snooze/reset sequences.
`timescale 1ns/1ps
module tb_chrono_alarm_chime;

  localparam int CLK_HZ     = 10_000;
  localparam int LOW_HZ     = 500;
  localparam int HIGH_HZ    = 1000;
  localparam int N_LOW      = 4;
  localparam int ALARM_SEC  = 30;
  localparam int SNOOZE_SEC = 5;
  localparam int MAX_SNOOZE = 3;
  localparam int SEC_LEN    = 50;
  localparam int QUIET_S    = 22;
  localparam int QUIET_E    = 7;

  logic       CP = 1'b0, nCR = 1'b0, SEC_TICK = 1'b0;
  logic [7:0] TIME_H = '0, TIME_M = '0, TIME_S = '0, ALARM_H = '0, ALARM_M = '0;
  logic       ALARM_EN = 1'b0, CHIME_EN = 1'b0, KEY_STOP = 1'b0, KEY_SNOOZE = 1'b0;
  logic       AUDIO, ALARM_ACTIVE, CHIME_ACTIVE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: 0 idle, 1 ringing, 2 snoozing; tones 0 silent, 1 low, 2 high.
  int   mode = 0, ring_sec = 0, snz_sec = 0, snoozes = 0;
  int   cur_tone = 0, change_cyc = 0, tod = 0;
  logic exp_chime = 1'b0;

  chrono_alarm_chime #(
    .CLK_HZ    (CLK_HZ),
    .LOW_HZ    (LOW_HZ),
    .HIGH_HZ   (HIGH_HZ),
    .DIV_W     (16),
    .N_LOW     (N_LOW),
    .ALARM_SEC (ALARM_SEC),
    .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .CP          (CP),
    .nCR         (nCR),
    .SEC_TICK    (SEC_TICK),
    .TIME_H      (TIME_H),
    .TIME_M      (TIME_M),
    .TIME_S      (TIME_S),
    .ALARM_H     (ALARM_H),
    .ALARM_M     (ALARM_M),
    .ALARM_EN    (ALARM_EN),
    .CHIME_EN    (CHIME_EN),
    .KEY_STOP    (KEY_STOP),
    .KEY_SNOOZE  (KEY_SNOOZE),
    .AUDIO       (AUDIO),
    .ALARM_ACTIVE(ALARM_ACTIVE),
    .CHIME_ACTIVE(CHIME_ACTIVE)
  );

  always #5 CP = ~CP;
  always @(posedge CP) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] h, m, s;
    logic       en;
    int         tone;
    logic       ca;
  } chime_vec_t;

  function automatic int bcd2int(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic is_quiet(int h);
`ifdef CHRONO_QUIET_HOURS_EN
    if (QUIET_S < QUIET_E) return (h >= QUIET_S) && (h < QUIET_E);
    if (QUIET_S > QUIET_E) return (h >= QUIET_S) || (h < QUIET_E);
    return 1'b0;
`else
    return (h < 0);
`endif
  endfunction

  function automatic int chime_tone(int h, int m, int s, logic en);
    int d;
    if (!en || m != 59 || is_quiet(h)) return 0;
    if (s == 59) return 2;
    d = 59 - s;
    if (d > 0 && d % 2 == 0 && d / 2 <= N_LOW) return 1;
    return 0;
  endfunction

  // Ideal square wave: low for one half-period after the tone starts, then alternating.
  function automatic logic exp_audio();
    int half;
    if (cur_tone == 0) return 1'b0;
    half = CLK_HZ / (2 * ((cur_tone == 1) ? LOW_HZ : HIGH_HZ));
    return ((cyc - change_cyc) / half) % 2 == 1;
  endfunction

  task automatic set_tone(input int t);
    if (t != cur_tone) change_cyc = cyc;
    cur_tone = t;
  endtask

  task automatic model_tick(input int h, input int m, input int s);
    int t;
    t = 0;
    case (mode)
      0: begin
        if (ALARM_EN && h == bcd2int(ALARM_H) && m == bcd2int(ALARM_M) && s == 0) begin
          mode = 1; ring_sec = 0; snoozes = 0; t = 2;
        end else begin
          t = chime_tone(h, m, s, CHIME_EN);
        end
      end
      1: begin
        ring_sec++;
        if (ring_sec == ALARM_SEC) mode = 0;
        else t = (ring_sec % 2 == 0) ? 2 : 0;
      end
      default: begin
        snz_sec++;
        if (snz_sec == SNOOZE_SEC) begin
          mode = 1; ring_sec = 0; t = 2;
        end
      end
    endcase
    exp_chime = (mode == 0) && (t != 0);
    set_tone(t);
  endtask

  task automatic model_key(input logic stop, input logic snz);
    if (mode == 0) return;
    if (stop) begin
      mode = 0;
      set_tone(0);
    end else if (snz && mode == 1 && snoozes < MAX_SNOOZE) begin
      mode = 2; snoozes++; snz_sec = 0;
      set_tone(0);
    end
  endtask

  // Checks every cycle of a span; one audio and one flag comparison per span.
  task automatic check_span(input string name, input int ncyc);
    int   bad_a, bad_f;
    logic got_a, want_a;
    logic [1:0] got_f, want_f;
    bad_a = -1; bad_f = -1;
    got_a = 1'b0; want_a = 1'b0; got_f = '0; want_f = '0;
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) @(negedge CP);
      if (AUDIO !== exp_audio() && bad_a < 0) begin
        bad_a = n; got_a = AUDIO; want_a = exp_audio();
      end
      if ({ALARM_ACTIVE, CHIME_ACTIVE} !== {mode != 0, exp_chime} && bad_f < 0) begin
        bad_f = n; got_f = {ALARM_ACTIVE, CHIME_ACTIVE}; want_f = {mode != 0, exp_chime};
      end
    end
    checks += 2;
    if (bad_a >= 0) begin
      errors++;
      $display("FAIL %s audio: cycle %0d got AUDIO=%b, expected %b", name, bad_a, got_a,
               want_a);
    end
    if (bad_f >= 0) begin
      errors++;
      $display("FAIL %s flags: cycle %0d got {ALARM_ACTIVE,CHIME_ACTIVE}=%b, expected %b",
               name, bad_f, got_f, want_f);
    end
  endtask

  task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge CP);
    TIME_H = h; TIME_M = m; TIME_S = s; SEC_TICK = 1'b1;
    @(negedge CP);
    SEC_TICK = 1'b0;
  endtask

  task automatic step(input string name);
    int h, m, s;
    h = (tod / 3600) % 24; m = (tod / 60) % 60; s = tod % 60;
    tick(int2bcd(h), int2bcd(m), int2bcd(s));
    model_tick(h, m, s);
    check_span($sformatf("%s@%02d:%02d:%02d", name, h, m, s), SEC_LEN);
    tod++;
  endtask

  task automatic steps(input string name, input int n);
    for (int i = 0; i < n; i++) step(name);
  endtask

  task automatic press(input logic stop, input logic snz, input string name);
    @(negedge CP);
    KEY_STOP = stop; KEY_SNOOZE = snz;
    @(negedge CP);
    KEY_STOP = 1'b0; KEY_SNOOZE = 1'b0;
    model_key(stop, snz);
    check_span(name, 1);
  endtask

  task automatic set_alarm(input int h, input int m);
    ALARM_H = int2bcd(h); ALARM_M = int2bcd(m);
  endtask

  chime_vec_t tbl [16];

  initial begin
    tbl[0]  = '{8'h10, 8'h59, 8'h49, 1'b1, 0, 1'b0};
    tbl[1]  = '{8'h10, 8'h59, 8'h50, 1'b1, 0, 1'b0};
    tbl[2]  = '{8'h10, 8'h59, 8'h51, 1'b1, 1, 1'b1};
    tbl[3]  = '{8'h10, 8'h59, 8'h52, 1'b1, 0, 1'b0};
    tbl[4]  = '{8'h10, 8'h59, 8'h53, 1'b1, 1, 1'b1};
    tbl[5]  = '{8'h10, 8'h59, 8'h54, 1'b1, 0, 1'b0};
    tbl[6]  = '{8'h10, 8'h59, 8'h55, 1'b1, 1, 1'b1};
    tbl[7]  = '{8'h10, 8'h59, 8'h56, 1'b1, 0, 1'b0};
    tbl[8]  = '{8'h10, 8'h59, 8'h57, 1'b1, 1, 1'b1};
    tbl[9]  = '{8'h10, 8'h59, 8'h58, 1'b1, 0, 1'b0};
    tbl[10] = '{8'h10, 8'h59, 8'h59, 1'b1, 2, 1'b1};
    tbl[11] = '{8'h11, 8'h00, 8'h00, 1'b1, 0, 1'b0};
    tbl[12] = '{8'h11, 8'h59, 8'h59, 1'b0, 0, 1'b0};
    tbl[13] = '{8'h11, 8'h59, 8'h57, 1'b1, 1, 1'b1};
    tbl[14] = '{8'h11, 8'h58, 8'h59, 1'b1, 0, 1'b0};
    tbl[15] = '{8'h12, 8'h59, 8'h59, 1'b1, 2, 1'b1};

    // Reset state
    repeat (2) @(negedge CP);
    checks++;
    if ({AUDIO, ALARM_ACTIVE, CHIME_ACTIVE} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got %b, expected 000", {AUDIO, ALARM_ACTIVE, CHIME_ACTIVE});
    end
    nCR = 1'b1;

    // Chime vector table
    for (int i = 0; i < 16; i++) begin
      CHIME_EN = tbl[i].en;
      tick(tbl[i].h, tbl[i].m, tbl[i].s);
      set_tone(tbl[i].tone);
      exp_chime = tbl[i].ca;
      check_span($sformatf("table%0d", i), SEC_LEN);
    end

    // Random chime seconds against the model
    for (int i = 0; i < 40; i++) begin
      int h, m, s;
      h = $urandom_range(23, 0);
      m = ($urandom_range(1, 0) == 1) ? 59 : $urandom_range(59, 0);
      s = $urandom_range(59, 44);
      CHIME_EN = ($urandom_range(3, 0) != 0);
      tick(int2bcd(h), int2bcd(m), int2bcd(s));
      model_tick(h, m, s);
      check_span($sformatf("rand%0d@%02d:%02d:%02d", i, h, m, s), SEC_LEN);
    end

    // Full ring, 07:30
    CHIME_EN = 1'b1; ALARM_EN = 1'b1;
    set_alarm(7, 30);
    tod = 7 * 3600 + 30 * 60 - 2;
    steps("ring_pre", 2);
    steps("ring", ALARM_SEC + 1);
    checks++;
    if (ALARM_ACTIVE !== 1'b0) begin
      errors++;
      $display("FAIL ring_end: ALARM_ACTIVE=%b, expected 0", ALARM_ACTIVE);
    end
    step("ring_post");

    // Snooze three times, fourth ignored, then stop
    set_alarm(8, 0);
    tod = 8 * 3600 - 1;
    steps("snz_pre", 3);
    press(1'b0, 1'b1, "snooze1");
    steps("snz1", SNOOZE_SEC + 1);
    press(1'b0, 1'b1, "snooze2");
    steps("snz2", SNOOZE_SEC + 2);
    press(1'b0, 1'b1, "snooze3");
    steps("snz3", SNOOZE_SEC + 1);
    press(1'b0, 1'b1, "snooze4_ignored");
    step("after_snz4");
    press(1'b1, 1'b0, "stop");
    steps("after_stop", 2);

    // Stop and snooze together
    set_alarm(9, 0);
    tod = 9 * 3600 - 1;
    steps("both_pre", 3);
    press(1'b1, 1'b1, "stop_and_snooze");
    step("both_post");

    // ALARM_EN dropped mid-beep
    set_alarm(10, 0);
    tod = 10 * 3600 - 1;
    steps("en_pre", 2);
    @(negedge CP);
    ALARM_EN = 1'b0;
    @(negedge CP);
    if (mode != 0) begin
      mode = 0;
      set_tone(0);
    end
    check_span("alarm_en_drop", 1);
    step("en_post");
    ALARM_EN = 1'b1;

    // Asynchronous reset mid-beep
    set_alarm(12, 0);
    tod = 12 * 3600;
    step("rst_pre");
    checks++;
    if (AUDIO !== exp_audio() || exp_audio() !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_beep: AUDIO=%b, expected 1", AUDIO);
    end
    #2 nCR = 1'b0;
    #1;
    checks++;
    if ({AUDIO, ALARM_ACTIVE, CHIME_ACTIVE} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got %b, expected 000", {AUDIO, ALARM_ACTIVE, CHIME_ACTIVE});
    end
    mode = 0; exp_chime = 1'b0;
    set_tone(0);
    @(negedge CP);
    nCR = 1'b1;
    steps("rst_post", 2);
    tod = 12 * 3600 + 59 * 60 + 58;
    steps("rst_chime", 2);

    // Alarm at 23:59 overrides the chime seconds
    set_alarm(23, 59);
    tod = 23 * 3600 + 59 * 60;
    steps("late_ring", 2);
    tod = 23 * 3600 + 59 * 60 + 50;
    steps("late_ring_chime", 10);
    press(1'b1, 1'b0, "late_stop");

`ifdef CHRONO_QUIET_HOURS_EN
    set_alarm(23, 0);
    tod = 23 * 3600 + 59 * 60 + 59;
    step("quiet23");
    tod = 6 * 3600 + 59 * 60 + 59;
    step("quiet06");
    tod = 7 * 3600 + 59 * 60 + 59;
    step("loud07");
    tod = 22 * 3600 + 59 * 60 + 59;
    steps("quiet_alarm", 3);
    press(1'b1, 1'b0, "quiet_stop");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chrono_alarm_chime.md
Name: chrono_alarm_chime

Overview:
- Second-generation hourly chime plus alarm clock sounder for the digital clock datapath.
- Consumes BCD time from the clock counters and a 1 Hz tick, and synthesises its own tone frequencies from the system clock; no external square-wave inputs.
- Adds a parametrised chime schedule, a programmable H:M alarm with stop and snooze, and alarm-over-chime priority.
- Drives the single buzzer output.

Parameters:
- CLK_HZ, 1_000_000: frequency of CP in Hz.
- LOW_HZ, 500: low chime tone frequency.
- HIGH_HZ, 1000: high chime tone and alarm tone frequency.
- DIV_W, 16: tone divider width; must satisfy CLK_HZ/(2*LOW_HZ) < 2^DIV_W.
- N_LOW, 4: number of low beeps before the high beep; legal range 1..29.
- ALARM_SEC, 30: alarm ring length in seconds per ring.
- SNOOZE_SEC, 300: snooze interval in seconds.
- MAX_SNOOZE, 3: number of snoozes honoured per alarm event.

Ports:
- CP  in  1  system clock.
- nCR  in  1  asynchronous active-low reset.
- SEC_TICK  in  1  one-CP pulse; TIME_* already hold the new second in that cycle.
- TIME_H  in  8  hour, BCD 00-23.
- TIME_M  in  8  minute, BCD.
- TIME_S  in  8  second, BCD.
- ALARM_H  in  8  alarm hour, BCD.
- ALARM_M  in  8  alarm minute, BCD.
- ALARM_EN  in  1  alarm armed (level).
- CHIME_EN  in  1  hourly chime enabled (level).
- KEY_STOP  in  1  debounced one-CP pulse.
- KEY_SNOOZE  in  1  debounced one-CP pulse.
- AUDIO  out  1  buzzer drive.
- ALARM_ACTIVE  out  1  high in RING and SNOOZE.
- CHIME_ACTIVE  out  1  high while a chime beep is sounding.

Behaviour:
- Reset (nCR=0, async): state IDLE; all counters 0; AUDIO=0, ALARM_ACTIVE=0, CHIME_ACTIVE=0.
- All evaluation happens on a CP edge where SEC_TICK=1; the decision is registered, so AUDIO/flags change one CP after the tick and hold for exactly one second (until the next tick's update).
- Chime match condition: CHIME_EN=1, TIME_M==8'h59, and either:
  - TIME_S==59-2k for some k in 1..N_LOW: low tone.
  - TIME_S==8'h59: high tone.
- Any other second gives silence from chime. BCD compare only; the k offsets are computed as constants at elaboration.
- FSM states: IDLE, RING, SNOOZE.
  - IDLE->RING: on a tick with ALARM_EN=1, TIME_H==ALARM_H, TIME_M==ALARM_M, TIME_S==8'h00. Ring counter=0, snooze count=0.
  - RING: high tone on ticks where ring counter is even, silence on odd. Ring counter increments per tick.
  - RING->IDLE: ring counter reaches ALARM_SEC, or KEY_STOP.
  - RING->SNOOZE: KEY_SNOOZE while snooze count<MAX_SNOOZE. Snooze count++, snooze counter=0, silence.
  - KEY_SNOOZE with snooze count==MAX_SNOOZE: ignored.
  - SNOOZE->RING: snooze counter reaches SNOOZE_SEC ticks; ring counter=0.
  - SNOOZE->IDLE: KEY_STOP.
  - Any state->IDLE: ALARM_EN=0, checked every CP and not gated by the tick; silence on the next CP.
- Keys act on the CP they arrive, independent of SEC_TICK. KEY_STOP wins over KEY_SNOOZE if both are asserted in the same cycle. Keys in IDLE are ignored.
- Priority: RING/SNOOZE suppress chime entirely; CHIME_ACTIVE=0 while ALARM_ACTIVE=1.
- Alarm at 23:59:xx with chime enabled: alarm wins.
- Tone generator:
  - Half-period count = CLK_HZ/(2*f) - 1.
  - Divider counter and phase are cleared whenever the tone select changes; AUDIO=0 during silence.
  - First AUDIO rise occurs one half-period after the select change.
- Counter widths: clog2 of the terminal values. No wrap, because counters are cleared on state entry.

Optional Feature:
- Macro CHRONO_QUIET_HOURS_EN.
- When defined: adds parameters QUIET_START (default 8'h22) and QUIET_END (default 8'h07), both BCD hours.
  - Chime is suppressed when TIME_H is in [QUIET_START, QUIET_END), wrapping past midnight when START>END.
  - START==END means never quiet.
  - Alarm is unaffected.
- When undefined: chime is governed by CHIME_EN alone; no extra parameters or logic.

Decomposition:
- Package chrono_pkg holds:
  - The state enum (IDLE/RING/SNOOZE).
  - The tone select enum (SILENT/LOW/HIGH).
  - A constant function for divider half-period computation.
  - A BCD less-than function for the quiet-hours compare.
- One sub-module chrono_tone_gen: CP, nCR, tone select in; AUDIO out; parametrised by CLK_HZ, LOW_HZ, HIGH_HZ, DIV_W.

Test Plan:
- Chime at 10:59:50..10:59:59 with N_LOW=4, CLK_HZ=10_000: low tone (period 20 CP) at seconds 51, 53, 55, 57; high tone (period 10 CP) at 59; silence at 50, 52, 54, 56, 58 and at 11:00:00.
- ALARM 07:30, tick at 07:30:00: ALARM_ACTIVE=1 one CP later; beeps on even ring seconds; IDLE after ALARM_SEC=30 ticks.
- RING, then KEY_SNOOZE: silence for SNOOZE_SEC=5 ticks, then RING restarts. After 3 snoozes a 4th KEY_SNOOZE is ignored; KEY_STOP returns to IDLE.
- KEY_STOP and KEY_SNOOZE in the same cycle: IDLE. ALARM_EN dropped mid-ring: AUDIO=0 and ALARM_ACTIVE=0 the next CP.
- nCR asserted mid-beep between CP edges: AUDIO, ALARM_ACTIVE and CHIME_ACTIVE go 0 immediately; no chime until the next matching tick.
- With CHRONO_QUIET_HOURS_EN, QUIET 22-07: chime is silent at 23:59:59 and 06:59:59 but sounds at 07:59:59; alarm at 23:00 still rings.
